pool_window_reorder: RTL and testbench

//  Converts a raster-order activation stream (row by row, one signed 8-bit value per handshake)

---
 rtl/pool_window_reorder.sv | 221 ++++++++++++++++++++++
 tb/tb_pool_window_reorder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_reorder.sv
// Reorders a raster-order activation stream into 2x2 window order (4 beats per window)
// using one row of line buffer plus two hold registers for the lower row of each window.
module pool_window_reorder #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 64,
    parameter int DIM_WIDTH  = 7
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  fmap_width,
    input  logic [DIM_WIDTH-1:0]  fmap_height,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [DIM_WIDTH-1:0] DIM_ZERO = {DIM_WIDTH{1'b0}};
    localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);
    localparam logic [DIM_WIDTH-1:0] DIM_TWO  = DIM_WIDTH'(2);
    localparam logic [DIM_WIDTH:0]   COL_STEP = (DIM_WIDTH + 1)'(2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_PAIR_A = 3'd2,
        S_PAIR_B = 3'd3,
        S_EMIT   = 3'd4,
        S_DROP   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t                state_q, state_d, eor_state_s;
    logic [DIM_WIDTH-1:0]  w_q, w_d, h_q, h_d;
    logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d;
    logic [1:0]            emit_idx_q, emit_idx_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d, hold2_q, hold2_d;
    logic [DATA_WIDTH-1:0] linebuf_q [MAX_WIDTH];
    logic                  lb_we_s;
    logic [AW-1:0]         lb_idx_s, rd_idx_s;
    logic                  xfer_s, col_last_s, row_last_s, row_penult_s, win_more_s;

    assign xfer_s       = in_valid & in_ready;
    assign col_last_s   = (col_q == (w_q - DIM_ONE));
    assign row_last_s   = (row_q == (h_q - DIM_ONE));
    assign row_penult_s = (row_q == (h_q - DIM_TWO));
    assign win_more_s   = (({1'b0, col_q} + COL_STEP) < {1'b0, w_q});
    assign lb_idx_s     = col_q[AW-1:0];
    // Window left column is always even, so the second upper pixel is col | 1.
    assign rd_idx_s     = lb_idx_s | AW'(emit_idx_q[0]);

    assign in_ready   = (state_q == S_FILL) || (state_q == S_PAIR_A) ||
                        (state_q == S_PAIR_B) || (state_q == S_DROP);
    assign out_valid  = (state_q == S_EMIT);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign frame_done = (state_q == S_DONE);

    // Window element selection; forced to zero outside the emit burst.
    always_comb begin
        out_data = {DATA_WIDTH{1'b0}};
        if (state_q == S_EMIT) begin
            case (emit_idx_q)
                2'd0, 2'd1: out_data = linebuf_q[rd_idx_s];
                2'd2:       out_data = hold_q;
                2'd3:       out_data = hold2_q;
                default:    out_data = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            out_data = {DATA_WIDTH{1'b0}};
        end
    end

    // Where to go once an odd row (or its trailing column) is finished.
    always_comb begin
        eor_state_s = S_FILL;
        if (row_last_s) begin
            eor_state_s = S_DONE;
        end else if (row_penult_s) begin
            eor_state_s = S_DROP;
        end else begin
            eor_state_s = S_FILL;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        row_d      = row_q;
        col_d      = col_q;
        emit_idx_d = emit_idx_q;
        hold_d     = hold_q;
        hold2_d    = hold2_q;
        lb_we_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_d        = fmap_width;
                    h_d        = fmap_height;
                    row_d      = DIM_ZERO;
                    col_d      = DIM_ZERO;
                    emit_idx_d = 2'd0;
                    if ((fmap_width == DIM_ZERO) || (fmap_height == DIM_ZERO)) begin
                        state_d = S_DONE;
                    end else if ((fmap_width == DIM_ONE) || (fmap_height == DIM_ONE)) begin
                        state_d = S_DROP;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FILL: begin
                if (xfer_s) begin
                    lb_we_s = 1'b1;
                    if (col_last_s) begin
                        col_d   = DIM_ZERO;
                        row_d   = row_q + DIM_ONE;
                        state_d = S_PAIR_A;
                    end else begin
                        col_d = col_q + DIM_ONE;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_PAIR_A: begin
                if (xfer_s) begin
                    if (col_last_s) begin
                        col_d   = DIM_ZERO;
                        row_d   = row_q + DIM_ONE;
                        state_d = eor_state_s;
                    end else begin
                        hold_d  = in_data;
                        state_d = S_PAIR_B;
                    end
                end else begin
                    state_d = S_PAIR_A;
                end
            end
            S_PAIR_B: begin
                if (xfer_s) begin
                    hold2_d    = in_data;
                    emit_idx_d = 2'd0;
                    state_d    = S_EMIT;
                end else begin
                    state_d = S_PAIR_B;
                end
            end
            S_EMIT: begin
                if (emit_idx_q == 2'd3) begin
                    emit_idx_d = 2'd0;
                    if (win_more_s) begin
                        col_d   = col_q + DIM_TWO;
                        state_d = S_PAIR_A;
                    end else begin
                        col_d   = DIM_ZERO;
                        row_d   = row_q + DIM_ONE;
                        state_d = eor_state_s;
                    end
                end else begin
                    emit_idx_d = emit_idx_q + 2'd1;
                end
            end
            S_DROP: begin
                if (xfer_s) begin
                    if (col_last_s) begin
                        col_d = DIM_ZERO;
                        if (row_last_s) begin
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + DIM_ONE;
                        end
                    end else begin
                        col_d = col_q + DIM_ONE;
                    end
                end else begin
                    state_d = S_DROP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            w_q        <= DIM_ZERO;
            h_q        <= DIM_ZERO;
            row_q      <= DIM_ZERO;
            col_q      <= DIM_ZERO;
            emit_idx_q <= 2'd0;
            hold_q     <= {DATA_WIDTH{1'b0}};
            hold2_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            row_q      <= row_d;
            col_q      <= col_d;
            emit_idx_q <= emit_idx_d;
            hold_q     <= hold_d;
            hold2_q    <= hold2_d;
        end
    end

    // Line buffer holding the upper row of the current row pair; not reset.
    always_ff @(posedge clock) begin
        if (lb_we_s) begin
            linebuf_q[lb_idx_s] <= in_data;
        end
    end
endmodule

// File: tb/tb_pool_window_reorder.sv
// Self-checking bench for pool_window_reorder: table of frame configurations with random
// pixels/gaps checked against a window-order reference model, plus reset-abort sequences.
module tb_pool_window_reorder;
    localparam int DW   = 8;
    localparam int MW   = 64;
    localparam int DIMW = 7;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [DIMW-1:0] fmap_width = 7'd0;
    logic [DIMW-1:0] fmap_height = 7'd0;
    logic [DW-1:0]   in_data = 8'd0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            busy;
    logic            frame_done;

    pool_window_reorder #(.DATA_WIDTH(DW), .MAX_WIDTH(MW), .DIM_WIDTH(DIMW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .fmap_width(fmap_width), .fmap_height(fmap_height),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cur_vec = -1;
    logic [7:0] got_q[$];
    int run_len = 0, burst_err = 0, ready_err = 0, zero_err = 0, done_cnt = 0;

    typedef struct {
        int w; int h; int gap; int mode; int beats; int mid_start;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0d expected %0d", name, cur_vec, act, exp);
        end
    endtask

    // Output monitor: collects beats and tracks burst shape / idle-zero / done pulses.
    always @(negedge clock) begin
        if (!reset_n) begin
            run_len = 0;
        end else begin
            if (out_valid) begin
                got_q.push_back(out_data);
                run_len++;
                if (in_ready) ready_err++;
            end else begin
                if (run_len != 0 && run_len != 4) burst_err++;
                run_len = 0;
                if (out_data != 8'd0) zero_err++;
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic do_abort();
        reset_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_out_data", 32'(out_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b1;
    endtask

    task automatic run_frame(input int w, input int h, input int gap, input int mode,
                             input int beats, input int mid_start, input int abort_beats,
                             output bit aborted);
        logic [7:0] pix[$];
        logic [7:0] exp_q[$];
        int explicit_vals[4] = '{-128, 127, -1, 0};
        int fed, cyc, n;
        aborted = 1'b0;
        for (int i = 0; i < w * h; i++) begin
            case (mode)
                0:       pix.push_back(8'(i + 1));
                1:       pix.push_back(8'(i));
                3:       pix.push_back(8'(explicit_vals[i % 4]));
                default: pix.push_back(8'($urandom));
            endcase
        end
        // Reference: each 2x2 window top-left, top-right, bottom-left, bottom-right.
        for (int r = 0; r + 1 < h; r += 2)
            for (int c = 0; c + 1 < w; c += 2) begin
                exp_q.push_back(pix[r * w + c]);
                exp_q.push_back(pix[r * w + c + 1]);
                exp_q.push_back(pix[(r + 1) * w + c]);
                exp_q.push_back(pix[(r + 1) * w + c + 1]);
            end
        got_q.delete();
        burst_err = 0; ready_err = 0; zero_err = 0; done_cnt = 0;

        @(posedge clock); #1;
        fmap_width = DIMW'(w); fmap_height = DIMW'(h); start = 1'b1; in_valid = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock); #1;
        chk("busy_after_start", 32'(busy), 32'((w > 0 && h > 0) ? 1 : 0));
        if (w * h == 0) chk("done_next_cycle", 32'(frame_done), 32'd1);
        @(posedge clock); #1;

        fed = 0; cyc = 0;
        while (fed < w * h && cyc < 4000 && !aborted) begin
            in_data  = pix[fed];
            in_valid = ($urandom_range(99) >= gap);
            if (mid_start != 0 && fed == 5) begin
                start = 1'b1; fmap_width = 7'd2; fmap_height = 7'd2;
            end else begin
                start = 1'b0; fmap_width = DIMW'(w); fmap_height = DIMW'(h);
            end
            @(negedge clock); #1;
            if (abort_beats > 0 && got_q.size() >= abort_beats) begin
                do_abort();
                aborted = 1'b1;
            end else begin
                if (in_valid && in_ready) fed++;
                @(posedge clock); #1;
                cyc++;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (!aborted) begin
            chk("all_pixels_accepted", 32'(fed), 32'(w * h));
            cyc = 0;
            while (done_cnt == 0 && cyc < 300 && !aborted) begin
                @(negedge clock); #1;
                if (abort_beats > 0 && got_q.size() >= abort_beats) begin
                    do_abort();
                    aborted = 1'b1;
                end
                cyc++;
            end
        end
        if (!aborted) begin
            repeat (3) @(negedge clock);
            #1;
            chk("beat_count", 32'(got_q.size()), 32'(beats));
            n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
            for (int i = 0; i < n; i++) chk("window_data", 32'(got_q[i]), 32'(exp_q[i]));
            chk("frame_done_pulses", 32'(done_cnt), 32'd1);
            chk("burst_len_4", 32'(burst_err), 32'd0);
            chk("ready_low_in_burst", 32'(ready_err), 32'd0);
            chk("data_zero_idle", 32'(zero_err), 32'd0);
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("ready_after_done", 32'(in_ready), 32'd0);
        end
    endtask

    initial begin
        bit ab;
        int t1[16] = '{1, 2, 5, 6, 3, 4, 7, 8, 9, 10, 13, 14, 11, 12, 15, 16};

        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        #2;
        reset_n = 1'b1;

        //            w   h  gap mode beats mid
        tbl[0]  = '{  4,  4,  0,  0,  16,  0};
        tbl[1]  = '{  5,  3,  0,  1,   8,  0};
        tbl[2]  = '{  4,  4, 40,  0,  16,  1};
        tbl[3]  = '{  2,  2,  0,  3,   4,  0};
        tbl[4]  = '{  0,  3,  0,  2,   0,  0};
        tbl[5]  = '{  3,  0,  0,  2,   0,  0};
        tbl[6]  = '{  1,  5, 20,  2,   0,  0};
        tbl[7]  = '{  6,  1,  0,  2,   0,  0};
        tbl[8]  = '{  7,  5, 30,  2,  24,  1};
        tbl[9]  = '{ 64,  2, 10,  2, 128,  0};
        tbl[10] = '{  3,  3,  0,  2,   4,  0};
        tbl[11] = '{  8,  6, 50,  2,  48,  0};

        for (int v = 0; v < 12; v++) begin
            cur_vec = v;
            run_frame(tbl[v].w, tbl[v].h, tbl[v].gap, tbl[v].mode, tbl[v].beats,
                      tbl[v].mid_start, 0, ab);
        end

        // Reset during the third beat of the first window, then a clean rerun.
        cur_vec = 100;
        run_frame(4, 4, 0, 0, 16, 0, 3, ab);
        chk("abort_taken", 32'(ab), 32'd1);
        cur_vec = 101;
        run_frame(4, 4, 0, 0, 16, 0, 0, ab);
        for (int i = 0; i < 16; i++) begin
            if (i < got_q.size()) chk("rerun_seq", 32'(got_q[i]), 32'(t1[i]));
            else chk("rerun_seq_missing", 32'(got_q.size()), 32'd16);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
